// File: rtl/mem_wb_buf_if.sv
// MEM->WB buffer bus: MEM-side handshake, WB-side handshake, forwarding lookup and retire count.
// The master modport is the environment around the buffer; the slave modport is the buffer itself.
interface mem_wb_buf_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] wd_i;
  logic              wreg_i;
  logic [DATA_W-1:0] wdata_i;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic [ADDR_W-1:0] fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output mem_valid, wd_i, wreg_i, wdata_i, wb_ready, fwd_raddr,
    input  mem_ready, wb_valid, wb_wd, wb_wreg, wb_wdata, fwd_hit, fwd_data, retire_cnt
  );

  modport slave (
    input  mem_valid, wd_i, wreg_i, wdata_i, wb_ready, fwd_raddr,
    output mem_ready, wb_valid, wb_wd, wb_wreg, wb_wdata, fwd_hit, fwd_data, retire_cnt
  );
endinterface

// File: rtl/mem_wb_buf.sv
// Two-entry elastic MEM->WB skid buffer with flush, forwarding lookup over
// buffered writes and a count of retired results.
module mem_wb_buf #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  mem_wb_buf_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  state_t           state;
  entry_t           head;
  entry_t           tail;
  entry_t           in_e;
  logic             push;
  logic             pop;
  logic             hit_head;
  logic             hit_tail;
  logic [CNT_W-1:0] cnt;

  assign in_e = '{wd: bus.wd_i, wreg: bus.wreg_i, wdata: bus.wdata_i};

  assign bus.mem_ready = rst & (state != FULL);
  assign push          = bus.mem_valid & bus.mem_ready;
  assign pop           = bus.wb_valid & bus.wb_ready;

  // Head register is kept at zero while empty, so wb_* read as a NOP then.
  assign bus.wb_valid   = (state != EMPTY);
  assign bus.wb_wd      = head.wd;
  assign bus.wb_wreg    = head.wreg;
  assign bus.wb_wdata   = head.wdata;
  assign bus.retire_cnt = cnt;

  // Occupancy FSM and entry storage; flush wins over any push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
    end else begin
      if (pop) cnt <= cnt + CNT_W'(1);
      if (flush) begin
        state <= EMPTY;
        head  <= '0;
        tail  <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (push) begin
              head  <= in_e;
              state <= ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              head <= in_e;
            end else if (push) begin
              tail  <= in_e;
              state <= FULL;
            end else if (pop) begin
              head  <= '0;
              state <= EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              head  <= tail;
              tail  <= '0;
              state <= ONE;
            end
          end
          default: begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
          end
        endcase
      end
    end
  end

  // Forwarding over registered entries only; register 0 never forwards, tail is newer.
  always_comb begin
    hit_head     = 1'b0;
    hit_tail     = 1'b0;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    if (bus.fwd_raddr != '0) begin
      hit_head = (state != EMPTY) && head.wreg && (head.wd == bus.fwd_raddr);
      hit_tail = (state == FULL) && tail.wreg && (tail.wd == bus.fwd_raddr);
    end
    bus.fwd_hit = hit_head | hit_tail;
    if (hit_tail)      bus.fwd_data = tail.wdata;
    else if (hit_head) bus.fwd_data = head.wdata;
  end

endmodule
